// File: rtl/fmul_seq.sv
// Sequencing and exception stage around the combinational fmul multiplier:
// operand capture, special-value screening and a small result FIFO.
module fmul_seq #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] mul_num1,
   output logic [31:0] mul_num2,
   input  logic [31:0] mul_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_flags
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never waits on ready, and payload is held while valid && !ready.
   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [31:0]   a_q, b_q;
   logic [CW-1:0] count;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   res_mem [DEPTH];
   logic [3:0]    flg_mem [DEPTH];

   logic          accept, push, pop;
   logic [31:0]   res_c;
   logic [3:0]    flg_c;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      push      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = (count < DEPTH_C);
            if (in_valid && in_ready) state_nxt = EXEC;
         end
         EXEC: begin
            push      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept    = in_valid && in_ready;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign mul_num1  = a_q;
   assign mul_num2  = b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         res_mem[wr_ptr] <= res_c;
         flg_mem[wr_ptr] <= flg_c;
      end
   end

   // Operand classification; flags are {invalid, overflow, underflow, zero}.
   logic [7:0]        ea, eb;
   logic              s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic signed [9:0] e_pre;

   assign ea     = a_q[30:23];
   assign eb     = b_q[30:23];
   assign s      = a_q[31] ^ b_q[31];
   assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != '0);
   assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != '0);
   assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == '0);
   assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == '0);
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);
   assign e_pre  = $signed({2'b00, ea} + {2'b00, eb} - 10'd127);

   always_comb begin
      res_c = {s, mul_out[30:0]};
      flg_c = 4'b0000;
      if (a_nan || b_nan) begin
         res_c = 32'h7FC0_0000;
         flg_c = 4'b1000;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         res_c = 32'h7FC0_0000;
         flg_c = 4'b1000;
      end else if (a_inf || b_inf) begin
         res_c = {s, 8'hFF, 23'h0};
      end else if (a_zero || b_zero) begin
         // Denormals are flushed to a signed zero.
         res_c = {s, 31'h0};
         flg_c = 4'b0001;
      end else if (e_pre > 10'sd254) begin
         res_c = {s, 8'hFF, 23'h0};
         flg_c = 4'b0100;
      end else if (e_pre < 10'sd0) begin
         res_c = {s, 31'h0};
         flg_c = 4'b0011;
      end else if (mul_out[30:23] == 8'hFF) begin
         res_c = {s, 8'hFF, 23'h0};
         flg_c = 4'b0100;
      end else if (mul_out[30:23] == 8'h00) begin
         res_c = {s, 31'h0};
         flg_c = 4'b0011;
      end
   end

   // Head outputs read as zero when empty so no stale entry is ever shown.
   assign out_result = out_valid ? res_mem[rd_ptr] : 32'h0;
   assign out_flags  = out_valid ? flg_mem[rd_ptr] : 4'h0;

endmodule
